// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU_Control codes, arbiter FSM states and default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam int ALU_DATA_WIDTH = 32;
   localparam int ALU_CTRL_WIDTH = 4;
   localparam int CNT_WIDTH      = 4;

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111,
      ALU_NOR = 4'b1100
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_if
// Description : Request/response channels of both ALU requesters.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = ALU_DATA_WIDTH,
   parameter int CTRL_WIDTH = ALU_CTRL_WIDTH
);
   logic                  req0_valid;
   logic                  req0_ready;
   logic [CTRL_WIDTH-1:0] req0_ctrl;
   logic [DATA_WIDTH-1:0] req0_a;
   logic [DATA_WIDTH-1:0] req0_b;
   logic                  req1_valid;
   logic                  req1_ready;
   logic [CTRL_WIDTH-1:0] req1_ctrl;
   logic [DATA_WIDTH-1:0] req1_a;
   logic [DATA_WIDTH-1:0] req1_b;
   logic                  resp0_valid;
   logic                  resp0_ready;
   logic [DATA_WIDTH-1:0] resp0_result;
   logic                  resp0_zero;
   logic                  resp1_valid;
   logic                  resp1_ready;
   logic [DATA_WIDTH-1:0] resp1_result;
   logic                  resp1_zero;

   modport master (
      output req0_valid, req0_ctrl, req0_a, req0_b,
      output req1_valid, req1_ctrl, req1_a, req1_b,
      output resp0_ready, resp1_ready,
      input  req0_ready, req1_ready,
      input  resp0_valid, resp0_result, resp0_zero,
      input  resp1_valid, resp1_result, resp1_zero
   );

   modport slave (
      input  req0_valid, req0_ctrl, req0_a, req0_b,
      input  req1_valid, req1_ctrl, req1_a, req1_b,
      input  resp0_ready, resp1_ready,
      output req0_ready, req1_ready,
      output resp0_valid, resp0_result, resp0_zero,
      output resp1_valid, resp1_result, resp1_zero
   );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter_rr_arbiter_2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_2
// Description : Two-way round-robin grant; on a tie the last winner yields.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_2 (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = valid;
      if (valid == 2'b11) begin
         grant = last_grant ? 2'b01 : 2'b10;
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one ALU between two requesters with round-robin grant
//               and a valid/ready response channel per requester.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH  = ALU_DATA_WIDTH,
   parameter int CTRL_WIDTH  = ALU_CTRL_WIDTH,
   parameter int ALU_LATENCY = 1
)(
   input  logic                  clock,
   input  logic                  reset,
   alu_arbiter_if.slave          bus,
   output logic [CTRL_WIDTH-1:0] alu_control,
   output logic [DATA_WIDTH-1:0] alu_operand_A,
   output logic [DATA_WIDTH-1:0] alu_operand_B,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic                  alu_zero
);

   generate
      if (ALU_LATENCY < 1 || ALU_LATENCY > 15) begin : g_bad_latency
         $error("alu_arbiter: ALU_LATENCY must lie in 1..15");
      end
   endgenerate

   localparam logic [CNT_WIDTH-1:0] c_latency = CNT_WIDTH'(ALU_LATENCY);

   arb_state_e            r_state;
   arb_state_e            w_state_nxt;
   logic [1:0]            w_grant;
   logic                  w_accept;
   logic                  w_resp_hs;
   logic                  r_owner;
   logic                  r_last_grant;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic [CTRL_WIDTH-1:0] r_alu_control;
   logic [DATA_WIDTH-1:0] r_alu_a;
   logic [DATA_WIDTH-1:0] r_alu_b;
   logic                  r_resp0_valid;
   logic                  r_resp1_valid;
   logic [DATA_WIDTH-1:0] r_resp0_result;
   logic [DATA_WIDTH-1:0] r_resp1_result;
   logic                  r_resp0_zero;
   logic                  r_resp1_zero;

   rr_arbiter_2 u_rr_arbiter_2 (
      .valid      ({bus.req1_valid, bus.req0_valid}),
      .last_grant (r_last_grant),
      .grant      (w_grant)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_resp_hs   = 1'b0;
      case (r_state)
         IDLE: begin
            if (|w_grant) begin
               w_accept    = 1'b1;
               w_state_nxt = EXEC;
            end
         end
         EXEC: begin
            if (r_cnt == CNT_WIDTH'(1)) begin
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            w_resp_hs = r_owner ? bus.resp1_ready : bus.resp0_ready;
            if (w_resp_hs) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Ready is gated by reset so nothing is accepted while reset is held.
   assign bus.req0_ready = reset & w_accept & w_grant[0];
   assign bus.req1_ready = reset & w_accept & w_grant[1];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_owner        <= 1'b0;
         r_last_grant   <= 1'b1;
         r_cnt          <= '0;
         r_alu_control  <= '0;
         r_alu_a        <= '0;
         r_alu_b        <= '0;
         r_resp0_valid  <= 1'b0;
         r_resp1_valid  <= 1'b0;
         r_resp0_result <= '0;
         r_resp1_result <= '0;
         r_resp0_zero   <= 1'b0;
         r_resp1_zero   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_alu_control <= w_grant[1] ? bus.req1_ctrl : bus.req0_ctrl;
            r_alu_a       <= w_grant[1] ? bus.req1_a    : bus.req0_a;
            r_alu_b       <= w_grant[1] ? bus.req1_b    : bus.req0_b;
            r_owner       <= w_grant[1];
            r_cnt         <= c_latency;
         end
         if (r_state == EXEC) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_WIDTH'(1)) begin
               if (r_owner) begin
                  r_resp1_result <= alu_result;
                  r_resp1_zero   <= alu_zero;
                  r_resp1_valid  <= 1'b1;
               end else begin
                  r_resp0_result <= alu_result;
                  r_resp0_zero   <= alu_zero;
                  r_resp0_valid  <= 1'b1;
               end
            end
         end
         if (w_resp_hs) begin
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_last_grant  <= r_owner;
         end
      end
   end

   assign alu_control      = r_alu_control;
   assign alu_operand_A    = r_alu_a;
   assign alu_operand_B    = r_alu_b;
   assign bus.resp0_valid  = r_resp0_valid;
   assign bus.resp1_valid  = r_resp1_valid;
   assign bus.resp0_result = r_resp0_result;
   assign bus.resp1_result = r_resp1_result;
   assign bus.resp0_zero   = r_resp0_zero;
   assign bus.resp1_zero   = r_resp1_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed and randomized checks of alu_arbiter with an ALU model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
   import alu_pkg::*;

   logic        clock;
   logic        reset;
   logic [3:0]  alu_control,   alu_control3;
   logic [31:0] alu_operand_A, alu_operand_A3;
   logic [31:0] alu_operand_B, alu_operand_B3;
   logic [31:0] alu_result,    alu_result3;
   logic        alu_zero,      alu_zero3;

   int n_checks   = 0;
   int n_errors   = 0;
   int model_last = 1;

   alu_arbiter_if #(.DATA_WIDTH(32), .CTRL_WIDTH(4)) bus  ();
   alu_arbiter_if #(.DATA_WIDTH(32), .CTRL_WIDTH(4)) bus3 ();

   alu_arbiter #(.DATA_WIDTH(32), .CTRL_WIDTH(4), .ALU_LATENCY(1)) dut (
      .clock(clock), .reset(reset), .bus(bus),
      .alu_control(alu_control), .alu_operand_A(alu_operand_A), .alu_operand_B(alu_operand_B),
      .alu_result(alu_result), .alu_zero(alu_zero)
   );

   alu_arbiter #(.DATA_WIDTH(32), .CTRL_WIDTH(4), .ALU_LATENCY(3)) dut3 (
      .clock(clock), .reset(reset), .bus(bus3),
      .alu_control(alu_control3), .alu_operand_A(alu_operand_A3), .alu_operand_B(alu_operand_B3),
      .alu_result(alu_result3), .alu_zero(alu_zero3)
   );

   // Behavioural ALU: {zero, result}
   function automatic logic [32:0] alu_f(logic [3:0] c, logic [31:0] a, logic [31:0] b);
      logic [31:0] res;
      case (c)
         4'b0000: res = a & b;
         4'b0001: res = a | b;
         4'b0010: res = a + b;
         4'b0110: res = a - b;
         4'b0111: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b1100: res = ~(a | b);
         default: res = a ^ b;
      endcase
      return {(res == 32'd0), res};
   endfunction

   assign {alu_zero,  alu_result}  = alu_f(alu_control,  alu_operand_A,  alu_operand_B);
   assign {alu_zero3, alu_result3} = alu_f(alu_control3, alu_operand_A3, alu_operand_B3);

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic set_req(int r, logic v, logic [3:0] c, logic [31:0] a, logic [31:0] b);
      if (r == 0) begin
         bus.req0_valid = v; bus.req0_ctrl = c; bus.req0_a = a; bus.req0_b = b;
      end else begin
         bus.req1_valid = v; bus.req1_ctrl = c; bus.req1_a = a; bus.req1_b = b;
      end
   endtask

   task automatic set_valid(int r, logic v);
      if (r == 0) bus.req0_valid = v;
      else        bus.req1_valid = v;
   endtask

   task automatic set_rready(int r, logic v);
      if (r == 0) bus.resp0_ready = v;
      else        bus.resp1_ready = v;
   endtask

   function automatic logic rdy(int r);
      return (r == 0) ? bus.req0_ready : bus.req1_ready;
   endfunction

   function automatic logic rvalid(int r);
      return (r == 0) ? bus.resp0_valid : bus.resp1_valid;
   endfunction

   function automatic logic [32:0] rresp(int r);
      return (r == 0) ? {bus.resp0_zero, bus.resp0_result} : {bus.resp1_zero, bus.resp1_result};
   endfunction

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      model_last = 1;
   endtask

   // One complete operation: requester r is expected to win the current IDLE cycle.
   task automatic transact(int r, logic [3:0] c, logic [31:0] a, logic [31:0] b, int bp, string tag);
      logic [32:0] exp;
      int lat;
      exp = alu_f(c, a, b);
      set_req(r, 1'b1, c, a, b);
      #1;
      check({tag, ".ready"}, 64'(rdy(r)), 64'd1);
      check({tag, ".other_ready"}, 64'(rdy(1 - r)), 64'd0);
      tick();
      set_valid(r, 1'b0);
      check({tag, ".alu_in"}, {alu_control, alu_operand_A, alu_operand_B}, {c, a, b});
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!rvalid(r) && lat < 20);
      check({tag, ".latency"}, 64'(lat), 64'd1);
      check({tag, ".resp"}, 64'(rresp(r)), 64'(exp));
      check({tag, ".other_resp_valid"}, 64'(rvalid(1 - r)), 64'd0);
      for (int i = 0; i < bp; i++) begin
         set_rready(r, 1'b0);
         set_rready(1 - r, 1'($urandom_range(0, 1)));
         tick();
         check({tag, ".bp_valid"}, 64'(rvalid(r)), 64'd1);
         check({tag, ".bp_resp"}, 64'(rresp(r)), 64'(exp));
         check({tag, ".bp_no_ready"}, {62'd0, rdy(1), rdy(0)}, 64'd0);
         check({tag, ".bp_other_valid"}, 64'(rvalid(1 - r)), 64'd0);
      end
      set_rready(r, 1'b1);
      set_rready(1 - r, 1'b0);
      tick();
      check({tag, ".valid_clear"}, 64'(rvalid(r)), 64'd0);
      set_rready(r, 1'b0);
      model_last = r;
   endtask

   logic [3:0]  codes [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1010};
   logic        pend  [2];
   logic [3:0]  pc    [2];
   logic [31:0] pa    [2];
   logic [31:0] pb    [2];

   initial begin
      int win;
      int t;
      int lat3;
      int spacing;
      reset = 1'b0;
      set_req(0, 1'b1, 4'b0010, 32'd7, 32'd11);
      set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
      bus.resp0_ready  = 1'b0;
      bus.resp1_ready  = 1'b0;
      bus3.req0_valid  = 1'b0; bus3.req0_ctrl = '0; bus3.req0_a = '0; bus3.req0_b = '0;
      bus3.req1_valid  = 1'b0; bus3.req1_ctrl = '0; bus3.req1_a = '0; bus3.req1_b = '0;
      bus3.resp0_ready = 1'b0;
      bus3.resp1_ready = 1'b0;
      tick();
      tick();
      // Reset state
      check("rst.ready", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
      check("rst.resp_valid", {62'd0, bus.resp1_valid, bus.resp0_valid}, 64'd0);
      check("rst.alu_in", {alu_control, alu_operand_A, alu_operand_B}, 64'd0);
      check("rst.resp", {bus.resp1_zero, bus.resp0_zero, bus.resp1_result}, 64'd0);
      set_valid(0, 1'b0);
      reset = 1'b1;
      model_last = 1;

      transact(0, 4'b0010, 32'd7, 32'd11, 0, "add");
      transact(1, 4'b0110, 32'd4, 32'd4, 0, "sub_zero");
      transact(1, 4'b0110, 32'd10, 32'd4, 0, "sub6");

      // Contention from reset: alternation starting with requester 0
      reset = 1'b0;
      set_req(0, 1'b1, 4'b0000, 32'd7, 32'd11);
      set_req(1, 1'b1, 4'b0001, 32'd2, 32'd4);
      tick();
      reset = 1'b1;
      model_last = 1;
      transact(0, 4'b0000, 32'd7, 32'd11, 0, "cont_and");
      transact(1, 4'b0001, 32'd2, 32'd4, 0, "cont_or");
      set_req(1, 1'b1, 4'b0010, 32'd5, 32'd6);
      transact(0, 4'b0010, 32'd1, 32'd2, 0, "cont_third");
      transact(1, 4'b0010, 32'd5, 32'd6, 0, "cont_drain");

      // Back-pressure with requester 1 waiting
      set_req(1, 1'b1, 4'b1100, 32'h0F0F_0000, 32'h0000_00FF);
      transact(0, 4'b0010, 32'd100, 32'd23, 5, "bp");
      transact(1, 4'b1100, 32'h0F0F_0000, 32'h0000_00FF, 0, "bp_after");

      // Reset during EXEC discards the operation
      set_req(0, 1'b1, 4'b0111, 32'd2, 32'd4);
      #1;
      check("rmid.ready", 64'(bus.req0_ready), 64'd1);
      tick();
      set_valid(0, 1'b0);
      set_req(1, 1'b1, 4'b0010, 32'd1, 32'd1);
      reset = 1'b0;
      #1;
      check("rmid.alu_in", {alu_control, alu_operand_A, alu_operand_B}, 64'd0);
      check("rmid.ready", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
      check("rmid.resp_valid", {62'd0, bus.resp1_valid, bus.resp0_valid}, 64'd0);
      set_valid(1, 1'b0);
      tick();
      reset = 1'b1;
      model_last = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rmid.no_resp", {62'd0, bus.resp1_valid, bus.resp0_valid}, 64'd0);
      end

      // Randomized traffic against the round-robin reference model
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      for (int it = 0; it < 40; it++) begin
         for (int r = 0; r < 2; r++) begin
            if (!pend[r] && $urandom_range(0, 1) == 1) begin
               pend[r] = 1'b1;
               pc[r] = codes[$urandom_range(0, 6)];
               pa[r] = $urandom;
               pb[r] = ($urandom_range(0, 3) == 0) ? pa[r] : $urandom;
               set_req(r, 1'b1, pc[r], pa[r], pb[r]);
            end
         end
         if (!pend[0] && !pend[1]) begin
            pend[0] = 1'b1;
            pc[0] = codes[$urandom_range(0, 6)];
            pa[0] = $urandom;
            pb[0] = $urandom;
            set_req(0, 1'b1, pc[0], pa[0], pb[0]);
         end
         win = (pend[0] && pend[1]) ? 1 - model_last : (pend[0] ? 0 : 1);
         transact(win, pc[win], pa[win], pb[win], $urandom_range(0, 3), "rnd");
         pend[win] = 1'b0;
      end

      // ALU_LATENCY = 3 instance: latency and accept-to-accept spacing
      bus3.resp0_ready = 1'b1;
      bus3.req0_valid  = 1'b1;
      bus3.req0_ctrl   = 4'b0010;
      bus3.req0_a      = 32'd2;
      bus3.req0_b      = 32'd4;
      #1;
      check("lat3.ready", 64'(bus3.req0_ready), 64'd1);
      tick();
      lat3 = 0;
      spacing = 0;
      t = 0;
      while (spacing == 0 && t < 20) begin
         tick();
         t++;
         if (bus3.resp0_valid && lat3 == 0) begin
            lat3 = t;
            check("lat3.result", {bus3.resp0_zero, bus3.resp0_result}, 64'd6);
         end
         if (bus3.req0_ready) spacing = t + 1;
      end
      check("lat3.latency", 64'(lat3), 64'd3);
      check("lat3.spacing", 64'(spacing), 64'd5);
      tick();
      bus3.req0_valid = 1'b0;
      repeat (6) tick();
      check("lat3.drained", 64'(bus3.resp0_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single ALU between two requesters: requester 0 is the execute stage; requester 1 is the branch/address helper.
- Arbitrates round-robin and drives ALU_Control and the operands from registers.
- Samples the ALU result and zero flag after a fixed latency, then returns them to the owning requester over a valid/ready response channel.
- Sits between the control/issue logic and the existing ALU instance in the CPU processor.

Parameters:
- DATA_WIDTH, 32, operand/result width
- CTRL_WIDTH, 4, ALU_Control width
- ALU_LATENCY, 1, edges from ALU inputs valid to result sampled; legal values are 1..15, elaboration error otherwise

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset; one clock domain, no other clocks
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  arbiter accepts requester 0 this cycle
- req0_ctrl  in  CTRL_WIDTH  ALU_Control for requester 0
- req0_a, req0_b  in  DATA_WIDTH  operands for requester 0
- req1_valid, req1_ready, req1_ctrl, req1_a, req1_b  same as requester 0, for requester 1
- resp0_valid  out  1  result for requester 0 is available
- resp0_ready  in  1  requester 0 consumes the result
- resp0_result  out  DATA_WIDTH  ALU result for requester 0
- resp0_zero  out  1  ALU zero flag for requester 0
- resp1_valid, resp1_ready, resp1_result, resp1_zero  same as requester 0, for requester 1
- alu_control  out  CTRL_WIDTH  to ALU ALU_Control
- alu_operand_A, alu_operand_B  out  DATA_WIDTH  to ALU operands
- alu_result  in  DATA_WIDTH  from ALU
- alu_zero  in  1  from ALU

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; alu_control/operands=0; resp*_result=0; resp*_zero=0; resp*_valid=0; owner=0; cnt=0; last_grant=1, so requester 0 wins the first tie. req*_ready=0 while reset is asserted.
- FSM states are IDLE, EXEC, RESP.
- IDLE:
  - req*_ready is combinational; exactly one is asserted, for the arbitration winner, and only if that requester's valid is high.
  - Winner: the single valid requester; if both are valid, the one not equal to last_grant.
  - Accept edge (valid&ready): register ctrl/a/b onto alu_*, owner=winner, cnt=ALU_LATENCY, go to EXEC.
- EXEC:
  - req*_ready=0; cnt decrements each edge.
  - On the edge where cnt==1: capture alu_result/alu_zero into the owner's resp regs, set resp<owner>_valid, go to RESP.
  - Net latency: result is sampled ALU_LATENCY edges after the accept edge.
- RESP:
  - resp<owner>_valid is held with result/zero stable until resp<owner>_ready=1 at an edge.
  - That edge: clear valid, last_grant=owner, go to IDLE.
  - Back-pressure may last indefinitely; no new accept in the meantime.
- Throughput: minimum spacing between accepts is ALU_LATENCY+2 edges, with no overlap of operations.
- ALU inputs hold their last values outside EXEC and are not cleared.
- The non-owner's resp_valid is always 0.
- ctrl codes are passed through unchecked; unsupported codes yield whatever the ALU produces.
- Requesters must hold valid and payload stable until accepted. Dropping valid before acceptance is legal and simply removes the request from arbitration.
- resp_ready asserted while resp_valid=0 is ignored.
- Reset mid-EXEC or mid-RESP: the operation is discarded and no response is issued.

Decomposition:
- alu_pkg holds:
  - ALU_Control encodings: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, NOR=1100.
  - FSM state encodings: IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
  - Default widths.
- One sub-module, rr_arbiter_2: inputs valid[1:0] and last_grant; outputs one-hot grant[1:0]; combinational.

Test Plan:
- Solo ADD: after reset, req0 ctrl=0010, a=7, b=11 -> accepted on first edge; resp0_valid after ALU_LATENCY edges with result=18, zero=0; resp1_valid stays 0.
- SUB to zero: req1 ctrl=0110, a=4, b=4 -> resp1_result=0, resp1_zero=1; then ctrl=0110, a=10, b=4 -> result=6, zero=0.
- Contention: both valid from reset; req0 ctrl=0000 (a=7, b=11), req1 ctrl=0001 (a=2, b=4) -> req0 granted first (result=3); req1 granted next (result=6); a third pair of simultaneous requests -> req0 wins again (alternation).
- Back-pressure: hold resp0_ready=0 for 5 cycles with req1_valid=1 -> resp0_valid and result stay stable, req1_ready stays 0; release -> req1 accepted on the following IDLE edge.
- Reset mid-operation: accept req0 SLT (a=2, b=4), assert reset during EXEC -> all outputs return to reset values immediately; no response after reset is released.
- Latency parameter: ALU_LATENCY=3, ADD a=2, b=4 -> resp0_valid exactly 3 edges after accept, result=6; accept-to-accept spacing = 5 edges with resp_ready held at 1.
